leader_inverse_search: RTL and testbench
========================================

Name: leader_inverse_search

Overview:
- Inverse of `leader_generator`, which maps a 5-bit index `t` to a 2-bit leader `l`. This block takes a target leader value and finds every `t` in 0..31 that produces it.
- It scans `t` sequentially through one internal instance of `leader_generator`.
- Each matching `t` is emitted on a valid/ready output handshake. A one-cycle `done` pulse and a hit count end the scan.
- Used wherever the design must recover index candidates from an observed leader symbol.

Parameters:
- FIRST_ONLY, 0: 1 = stop after the first accepted match; 0 = report all matches.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a search; sampled only in IDLE
- target  input  2  leader value to search for; latched on accepted start
- busy  output  1  high in every state except IDLE
- match_valid  output  1  `match_t` holds a matching index
- match_ready  input  1  consumer accepts `match_t` when high with `match_valid`
- match_t  output  5  matching index `t`
- done  output  1  one-cycle pulse at end of search
- match_count  output  6  matches accepted in the current/last search (0..32)

Behaviour:
- Reset (rst=1 at a rising edge), from any state including mid-search:
  - state=IDLE
  - busy=0, match_valid=0, match_t=0, done=0, match_count=0
  - internal t_idx=0, latched target=0
- Internal registers: t_idx[4:0] drives `leader_generator.t`; tgt[1:0] holds the latched target.
- States: IDLE, SCAN, HOLD, DONE.
- IDLE, on start=1:
  - tgt<=target, t_idx<=0, match_count<=0 → SCAN.
  - start=0: stay in IDLE.
- SCAN (one index per cycle), compare `leader_generator(t_idx)` with tgt:
  - equal: match_t<=t_idx, match_valid<=1 → HOLD.
  - not equal and t_idx==31: → DONE.
  - not equal otherwise: t_idx<=t_idx+1.
- HOLD:
  - match_valid and match_t are held stable while match_ready=0. There is no timeout; backpressure is unbounded.
  - On match_ready=1: match_valid<=0, match_count<=match_count+1.
  - Then, if FIRST_ONLY=1 or t_idx==31: → DONE.
  - Otherwise: t_idx<=t_idx+1 → SCAN.
  - Minimum one cycle in HOLD even if ready is already high.
- DONE:
  - done=1 for exactly this one cycle, then → IDLE.
  - busy=1 during DONE.
- start while busy=1 is ignored; no queuing.
- match_count holds its final value through IDLE until the next accepted start clears it.
- Wrap-around: t_idx never increments past 31, and no 5-bit wrap to 0 is permitted.
- Latency:
  - start→first SCAN cycle: 1 clock.
  - Zero-match search: 32 SCAN cycles + 1 DONE; done is seen 33 cycles after the start edge.
  - Each match adds 1 HOLD cycle plus backpressure.
- All outputs are registered; `leader_generator` is the only combinational logic in the compare path.

Test Plan:
- All-targets sweep:
  - Stimulus: for target=0,1,2,3 with FIRST_ONLY=0 and match_ready tied 1, start once each.
  - Required: emitted `match_t` sequence is strictly ascending and equals exactly the indices `i` where outputs_L.txt[i]==target.
  - Required: match_count equals that entry count, and the four counts sum to 32.
- Zero-match timing:
  - Stimulus: pick a target absent from outputs_L.txt, or force it with a stub generator returning a constant 0 and target=3.
  - Required: no match_valid, done high exactly 33 cycles after start, match_count=0.
- Backpressure:
  - Stimulus: target with ≥2 hits, match_ready=0 for 10 cycles on each match.
  - Required: match_valid and match_t stable throughout, t_idx not advanced, final count correct.
- FIRST_ONLY=1:
  - Stimulus: target=outputs_L.txt[k] for the smallest such k.
  - Required: exactly one handshake with match_t=k, then done, match_count=1.
- Reset mid-operation:
  - Stimulus: assert rst in SCAN at t_idx≈12, and separately in HOLD.
  - Required: next cycle all outputs are 0 and the block is in IDLE.
  - Required: a new start with the same target reproduces the full, correct match list.
- Start while busy / boundary:
  - Stimulus: pulse start with a different target mid-scan.
  - Required: ignored; results are for the original target.
  - Stimulus: target whose only or last hit is t=31.
  - Required: match_t=31 accepted, then DONE with no extra SCAN cycle.

Source files
------------

// File: rtl/leader_inverse_search_if.sv
// Request/result bundle for leader_inverse_search: start/target in,
// match stream with valid/ready out, plus done/busy/match_count status.
interface leader_inverse_search_if;
  logic       start;
  logic [1:0] target;
  logic       busy;
  logic       match_valid;
  logic       match_ready;
  logic [4:0] match_t;
  logic       done;
  logic [5:0] match_count;

  modport master (
    output start, target, match_ready,
    input  busy, match_valid, match_t, done, match_count
  );

  modport slave (
    input  start, target, match_ready,
    output busy, match_valid, match_t, done, match_count
  );
endinterface

// File: rtl/leader_inverse_search.sv
// leader_inverse_search: scans t = 0..31 through leader_generator and emits
// every index whose leader equals the latched target on a valid/ready stream.
// leader_generator is the forward map t -> l (2-bit leader) it inverts.

module leader_generator (
  input  logic [4:0] t,
  output logic [1:0] l
);
  // Fixed leader lookup; target value 3 never occurs.
  always_comb begin
    l = '0;
    case (t)
      5'd0, 5'd4, 5'd5, 5'd10, 5'd13, 5'd19, 5'd22, 5'd25, 5'd30: l = 2'd1;
      5'd2, 5'd7, 5'd11, 5'd16, 5'd21, 5'd28, 5'd31:               l = 2'd2;
      default:                                                      l = 2'd0;
    endcase
  end
endmodule

module leader_inverse_search #(
  parameter int FIRST_ONLY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  leader_inverse_search_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic [4:0] t_idx;
  logic [1:0] tgt;
  logic [1:0] lead;
  logic       busy_r;
  logic       match_valid_r;
  logic [4:0] match_t_r;
  logic       done_r;
  logic [5:0] match_count_r;

  leader_generator u_gen (
    .t (t_idx),
    .l (lead)
  );

  // Search sequencer; done is raised on entry to DONE so it is high for exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      t_idx         <= '0;
      tgt           <= '0;
      busy_r        <= 1'b0;
      match_valid_r <= 1'b0;
      match_t_r     <= '0;
      done_r        <= 1'b0;
      match_count_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tgt           <= bus.target;
            t_idx         <= '0;
            match_count_r <= '0;
            busy_r        <= 1'b1;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (lead == tgt) begin
            match_t_r     <= t_idx;
            match_valid_r <= 1'b1;
            state         <= HOLD;
          end else if (t_idx == 5'd31) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            t_idx <= t_idx + 5'd1;
          end
        end
        HOLD: begin
          if (bus.match_ready) begin
            match_valid_r <= 1'b0;
            match_count_r <= match_count_r + 6'd1;
            if (FIRST_ONLY != 0 || t_idx == 5'd31) begin
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              t_idx <= t_idx + 5'd1;
              state <= SCAN;
            end
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.match_valid = match_valid_r;
  assign bus.match_t     = match_t_r;
  assign bus.done        = done_r;
  assign bus.match_count = match_count_r;
endmodule

// File: tb/tb_leader_inverse_search.sv
// Directed bench for leader_inverse_search: one DUT with FIRST_ONLY=0 and one
// with FIRST_ONLY=1, checked against a reference leader table.
module tb_leader_inverse_search;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  leader_inverse_search_if bus0 ();
  leader_inverse_search_if bus1 ();

  leader_inverse_search #(.FIRST_ONLY(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  leader_inverse_search #(.FIRST_ONLY(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference leader per index t.
  logic [1:0] LT [32] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2,
                          2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0,
                          2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0,
                          2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2};

  int         exp_n;
  logic [4:0] exp_t [32];

  int         got_n;
  logic [4:0] got_t [32];
  int         got_cycles;
  logic       done_after;
  logic       busy_after;
  bit         unstable;
  bit         tidx_moved;
  bit         saw_mv;
  int         last_acc;
  logic [5:0] got_count;

  task automatic build_exp(input logic [1:0] tg);
    exp_n = 0;
    for (int i = 0; i < 32; i++)
      if (LT[i] == tg) begin
        exp_t[exp_n] = 5'(i);
        exp_n++;
      end
  endtask

  task automatic set_req(input int sel, input logic st, input logic [1:0] tg);
    if (sel == 0) begin bus0.start = st; bus0.target = tg; end
    else          begin bus1.start = st; bus1.target = tg; end
  endtask

  task automatic set_ready(input int sel, input logic r);
    if (sel == 0) bus0.match_ready = r; else bus1.match_ready = r;
  endtask

  // Runs one search, collecting accepted matches; stall = ready-low cycles per match,
  // poke = cycle at which a conflicting start is pulsed (0 = none).
  task automatic search(input int sel, input logic [1:0] tg, input int stall, input int poke);
    logic mv, dn;
    logic [4:0] mt, held;
    bit in_m;
    int hc;
    logic rdy_def;
    got_n = 0; got_cycles = -1; unstable = 0; tidx_moved = 0; saw_mv = 0; last_acc = -1;
    in_m = 0; hc = 0; held = '0;
    rdy_def = (stall == 0);
    set_ready(sel, rdy_def);
    set_req(sel, 1'b1, tg);
    @(posedge clk); #1;
    set_req(sel, 1'b0, tg);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (sel == 0) begin mv = bus0.match_valid; mt = bus0.match_t; dn = bus0.done; end
      else          begin mv = bus1.match_valid; mt = bus1.match_t; dn = bus1.done; end
      if (poke != 0 && cyc == poke)     set_req(sel, 1'b1, ~tg);
      if (poke != 0 && cyc == poke + 1) set_req(sel, 1'b0, tg);
      if (dn) begin
        got_cycles = cyc;
        break;
      end
      if (mv) begin
        saw_mv = 1;
        if (!in_m) begin in_m = 1; held = mt; hc = 0; end
        else if (mt !== held) unstable = 1;
        if (sel == 0 && u0.t_idx !== held) tidx_moved = 1;
        if (hc < stall) begin
          set_ready(sel, 1'b0);
          hc++;
        end else begin
          set_ready(sel, 1'b1);
          if (got_n < 32) got_t[got_n] = mt;
          got_n++;
          last_acc = cyc;
          in_m = 0;
        end
      end else begin
        set_ready(sel, rdy_def);
      end
      @(posedge clk); #1;
    end
    got_count = (sel == 0) ? bus0.match_count : bus1.match_count;
    set_req(sel, 1'b0, tg);
    @(posedge clk); #1;
    done_after = (sel == 0) ? bus0.done : bus1.done;
    busy_after = (sel == 0) ? bus0.busy : bus1.busy;
    set_ready(sel, 1'b1);
  endtask

  task automatic test_reset;
    checks++; if (bus0.busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %0d expected 0", bus0.busy); end
    checks++; if (bus0.match_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", bus0.match_valid); end
    checks++; if (bus0.match_t !== 5'd0)     begin errors++; $display("FAIL reset_t: got %0d expected 0", bus0.match_t); end
    checks++; if (bus0.done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %0d expected 0", bus0.done); end
    checks++; if (bus0.match_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus0.match_count); end
  endtask

  task automatic test_all_targets;
    int sum;
    sum = 0;
    for (int tg = 0; tg < 4; tg++) begin
      build_exp(2'(tg));
      search(0, 2'(tg), 0, 0);
      checks++; if (got_cycles < 0) begin errors++; $display("FAIL sweep_timeout tg=%0d: no done within bound", tg); end
      checks++; if (got_n != exp_n) begin errors++; $display("FAIL sweep_n tg=%0d: got %0d expected %0d", tg, got_n, exp_n); end
      for (int i = 0; i < exp_n && i < got_n; i++) begin
        checks++;
        if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL sweep_t tg=%0d idx=%0d: got %0d expected %0d", tg, i, got_t[i], exp_t[i]); end
      end
      for (int i = 1; i < got_n && i < 32; i++) begin
        checks++;
        if (got_t[i] <= got_t[i-1]) begin errors++; $display("FAIL sweep_order tg=%0d idx=%0d: got %0d after %0d", tg, i, got_t[i], got_t[i-1]); end
      end
      checks++; if (got_count !== 6'(exp_n)) begin errors++; $display("FAIL sweep_count tg=%0d: got %0d expected %0d", tg, got_count, exp_n); end
      checks++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin errors++; $display("FAIL sweep_done_width tg=%0d: done=%0d busy=%0d expected 0 0", tg, done_after, busy_after); end
      sum += int'(got_count);
    end
    checks++; if (sum != 32) begin errors++; $display("FAIL sweep_sum: got %0d expected 32", sum); end
  endtask

  task automatic test_zero_match;
    search(0, 2'd3, 0, 0);
    checks++; if (saw_mv)            begin errors++; $display("FAIL zero_valid: got 1 expected 0"); end
    checks++; if (got_cycles != 33)  begin errors++; $display("FAIL zero_latency: got %0d expected 33", got_cycles); end
    checks++; if (got_count !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", got_count); end
  endtask

  task automatic test_backpressure;
    build_exp(2'd2);
    search(0, 2'd2, 10, 0);
    checks++; if (unstable)   begin errors++; $display("FAIL bp_stable: got unstable expected stable"); end
    checks++; if (tidx_moved) begin errors++; $display("FAIL bp_tidx: got moved expected held"); end
    checks++; if (got_n != exp_n) begin errors++; $display("FAIL bp_n: got %0d expected %0d", got_n, exp_n); end
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL bp_t idx=%0d: got %0d expected %0d", i, got_t[i], exp_t[i]); end
    end
    checks++; if (got_count !== 6'(exp_n)) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_count, exp_n); end
  endtask

  task automatic test_first_only;
    for (int tg = 0; tg < 3; tg++) begin
      build_exp(2'(tg));
      search(1, 2'(tg), 0, 0);
      checks++; if (got_n != 1) begin errors++; $display("FAIL first_n tg=%0d: got %0d expected 1", tg, got_n); end
      checks++; if (got_n >= 1 && got_t[0] !== exp_t[0]) begin errors++; $display("FAIL first_t tg=%0d: got %0d expected %0d", tg, got_t[0], exp_t[0]); end
      checks++; if (got_cycles != last_acc + 1) begin errors++; $display("FAIL first_done tg=%0d: got cycle %0d expected %0d", tg, got_cycles, last_acc + 1); end
      checks++; if (got_count !== 6'd1) begin errors++; $display("FAIL first_count tg=%0d: got %0d expected 1", tg, got_count); end
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    for (int mode = 0; mode < 2; mode++) begin
      logic [1:0] tg;
      tg = (mode == 0) ? 2'd1 : 2'd2;
      bus0.match_ready = (mode == 0);
      set_req(0, 1'b1, tg);
      @(posedge clk); #1;
      set_req(0, 1'b0, tg);
      seen = 0;
      if (mode == 0) begin
        repeat (16) @(posedge clk);
        #1;
        seen = 1;
      end else begin
        for (int c = 0; c < 40 && !seen; c++) begin
          if (bus0.match_valid) seen = 1; else begin @(posedge clk); #1; end
        end
      end
      checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach mode=%0d: got no match expected HOLD", mode); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (bus0.busy !== 1'b0 || bus0.match_valid !== 1'b0 || bus0.match_t !== 5'd0 ||
          bus0.done !== 1'b0 || bus0.match_count !== 6'd0) begin
        errors++;
        $display("FAIL rstmid_outputs mode=%0d: got busy=%0d valid=%0d t=%0d done=%0d count=%0d expected all 0",
                 mode, bus0.busy, bus0.match_valid, bus0.match_t, bus0.done, bus0.match_count);
      end
      build_exp(tg);
      search(0, tg, 0, 0);
      checks++; if (got_n != exp_n) begin errors++; $display("FAIL rstmid_n mode=%0d: got %0d expected %0d", mode, got_n, exp_n); end
      for (int i = 0; i < exp_n && i < got_n; i++) begin
        checks++;
        if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL rstmid_t mode=%0d idx=%0d: got %0d expected %0d", mode, i, got_t[i], exp_t[i]); end
      end
    end
  endtask

  task automatic test_start_busy;
    build_exp(2'd0);
    search(0, 2'd0, 0, 5);
    checks++; if (got_n != exp_n) begin errors++; $display("FAIL busy_start_n: got %0d expected %0d", got_n, exp_n); end
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL busy_start_t idx=%0d: got %0d expected %0d", i, got_t[i], exp_t[i]); end
    end
    checks++; if (got_count !== 6'(exp_n)) begin errors++; $display("FAIL busy_start_count: got %0d expected %0d", got_count, exp_n); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got busy=%0d expected 0", busy_after); end
  endtask

  task automatic test_last_index;
    search(0, 2'd2, 0, 0);
    checks++; if (got_n < 1 || got_t[(got_n < 1) ? 0 : got_n - 1] !== 5'd31) begin
      errors++; $display("FAIL last_t: got %0d expected 31", (got_n < 1) ? 0 : got_t[got_n - 1]);
    end
    checks++; if (got_cycles != last_acc + 1) begin errors++; $display("FAIL last_done: got cycle %0d expected %0d", got_cycles, last_acc + 1); end
  endtask

  initial begin
    rst = 1'b1;
    bus0.start = 1'b0; bus0.target = '0; bus0.match_ready = 1'b1;
    bus1.start = 1'b0; bus1.target = '0; bus1.match_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_all_targets;
    test_zero_match;
    test_backpressure;
    test_first_only;
    test_reset_mid;
    test_start_busy;
    test_last_index;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
